// File: rtl/chroma_upsample_stream_pkg.sv
// Shared types and constants for the chroma upsampler: modes, channel ids, FSM states, block type.
// The sub-block count is carried as its last index (N-1): 0, 1 or 3.
package chroma_upsample_stream_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_BLK    = 8;

  typedef enum logic [1:0] {
    MODE_444 = 2'd0,
    MODE_422 = 2'd1,
    MODE_420 = 2'd2
  } mode_e;

  localparam logic [1:0] CH_Y  = 2'd0;
  localparam logic [1:0] CH_CB = 2'd1;
  localparam logic [1:0] CH_CR = 2'd2;

  localparam logic [1:0] LAST_444 = 2'd0;
  localparam logic [1:0] LAST_422 = 2'd1;
  localparam logic [1:0] LAST_420 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef logic signed [DEF_DATA_W-1:0] blk_t [DEF_BLK][DEF_BLK];

  function automatic logic [1:0] last_idx_of(input logic [1:0] mode, input logic chroma);
    if (chroma && mode == MODE_420) return LAST_420;
    if (chroma && mode == MODE_422) return LAST_422;
    return LAST_444;
  endfunction

endpackage

// File: rtl/chroma_upsample_stream_select.sv
// Combinational nearest-neighbour sub-block picker: zero latency, no handshake.
// Sample (r,c) lives at bits [(r*BLK+c)*DATA_W +: DATA_W] of every flat block.
module chroma_upsample_stream_select
  import chroma_upsample_stream_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int BLK    = 8
) (
  input  logic [BLK*BLK*DATA_W-1:0] hold,
  input  logic [1:0]                last_idx,
  input  logic [1:0]                idx,
  output logic [BLK*BLK*DATA_W-1:0] blk
);

  localparam int H = BLK / 2;

  for (genvar r = 0; r < BLK; r++) begin : g_row
    for (genvar c = 0; c < BLK; c++) begin : g_col
      logic [DATA_W-1:0] quad [4];
      logic [DATA_W-1:0] half [2];

      // Quadrants ordered TL, TR, BL, BR so the sub-block index selects directly
      assign quad[0] = hold[((r/2)*BLK + c/2)*DATA_W +: DATA_W];
      assign quad[1] = hold[((r/2)*BLK + H + c/2)*DATA_W +: DATA_W];
      assign quad[2] = hold[((H + r/2)*BLK + c/2)*DATA_W +: DATA_W];
      assign quad[3] = hold[((H + r/2)*BLK + H + c/2)*DATA_W +: DATA_W];
      assign half[0] = hold[(r*BLK + c/2)*DATA_W +: DATA_W];
      assign half[1] = hold[(r*BLK + H + c/2)*DATA_W +: DATA_W];

      assign blk[(r*BLK + c)*DATA_W +: DATA_W] =
        (last_idx == LAST_420) ? quad[idx] :
        (last_idx == LAST_422) ? half[idx[0]] :
                                 hold[(r*BLK + c)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/chroma_upsample_stream.sv
// Streaming chroma upsampler: one 8x8 block in, 1/2/4 replicated blocks out; first output one cycle after accept.
// Output holds under backpressure; a new block is accepted on the last output handshake for zero-bubble streaming.
module chroma_upsample_stream
  import chroma_upsample_stream_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int BLK    = 8,
  parameter int CH_W   = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH_W-1:0]           in_ch,
  input  logic [BLK*BLK*DATA_W-1:0] in_block,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BLK*BLK*DATA_W-1:0] out_block,
  output logic [CH_W-1:0]           out_ch,
  output logic [1:0]                out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err_ch
);

  localparam int BW = BLK * BLK * DATA_W;

  state_e          state, state_n;
  logic [BW-1:0]   hold_q, sel_blk, nxt_blk;
  logic [1:0]      last_q, sel_last, sel_idx, new_last;
  logic            accept, illegal, take, out_hs, is_chroma;

  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_last  = out_valid && (out_idx == last_q);
  assign out_hs    = out_valid && out_ready;
  assign in_ready  = (state == IDLE) || (out_hs && out_last);
  assign accept    = in_valid && in_ready;
  assign illegal   = (in_ch > CH_W'(CH_CR));
  assign take      = accept && !illegal;
  assign is_chroma = (in_ch != CH_W'(CH_Y)) && !illegal;
  assign new_last  = last_idx_of(mode, is_chroma);

  // A freshly accepted block feeds the selector directly so sub-block 0 is ready next cycle
  assign sel_blk  = take ? in_block : hold_q;
  assign sel_last = take ? new_last : last_q;
  assign sel_idx  = take ? 2'd0 : out_idx + 2'd1;

  chroma_upsample_stream_select #(
    .DATA_W (DATA_W),
    .BLK    (BLK)
  ) u_select (
    .hold     (sel_blk),
    .last_idx (sel_last),
    .idx      (sel_idx),
    .blk      (nxt_blk)
  );

  always_comb begin
    state_n = state;
    if (out_hs && out_last) state_n = IDLE;
    if (take)               state_n = EMIT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q    <= '0;
      last_q    <= '0;
      out_block <= '0;
      out_ch    <= '0;
      out_idx   <= '0;
      err_ch    <= 1'b0;
    end else begin
      err_ch <= accept && illegal;
      if (take) begin
        hold_q    <= in_block;
        last_q    <= new_last;
        out_ch    <= in_ch;
        out_idx   <= 2'd0;
        out_block <= nxt_blk;
      end else if (out_hs && !out_last) begin
        out_idx   <= sel_idx;
        out_block <= nxt_blk;
      end else if (out_hs) begin
        out_idx <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_chroma_upsample_stream.sv
// Bench for chroma_upsample_stream: directed scenarios then random blocks/modes/stalls against a reference model.
module tb_chroma_upsample_stream;
  import chroma_upsample_stream_pkg::*;

  localparam int DATA_W = 9;
  localparam int BLK    = 8;
  localparam int CH_W   = 2;
  localparam int BW     = BLK * BLK * DATA_W;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [1:0]      mode;
  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [BW-1:0]   in_block;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   out_block;
  logic [CH_W-1:0] out_ch;
  logic [1:0]      out_idx;
  logic            out_last;
  logic            busy;
  logic            err_ch;

  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0] got [4];

  always #5 clock = ~clock;

  chroma_upsample_stream #(.DATA_W(DATA_W), .BLK(BLK), .CH_W(CH_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_ch    (out_ch),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .err_ch    (err_ch)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [BW-1:0] pack(input blk_t b);
    logic [BW-1:0] v;
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        v[(r*BLK + c)*DATA_W +: DATA_W] = b[r][c];
    return v;
  endfunction

  function automatic logic signed [DATA_W-1:0] smp(input logic [BW-1:0] v, input int r, input int c);
    return v[(r*BLK + c)*DATA_W +: DATA_W];
  endfunction

  function automatic int n_of(input int md, input int ch);
    if ((ch == 1 || ch == 2) && md == 2) return 4;
    if ((ch == 1 || ch == 2) && md == 1) return 2;
    return 1;
  endfunction

  // Reference: nearest-neighbour source pixel for output (r,c) of sub-block k
  function automatic logic signed [DATA_W-1:0] model(input blk_t b, input int n, input int k, input int r, input int c);
    int h = BLK / 2;
    if (n == 4) return b[(k / 2) * h + r / 2][(k % 2) * h + c / 2];
    if (n == 2) return b[r][k * h + c / 2];
    return b[r][c];
  endfunction

  function automatic logic [BW-1:0] exp_vec(input blk_t b, input int n, input int k);
    logic [BW-1:0] v;
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        v[(r*BLK + c)*DATA_W +: DATA_W] = model(b, n, k, r, c);
    return v;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        b[r][c] = DATA_W'($urandom);
    return b;
  endfunction

  // Offer a block and return just after the posedge on which it was accepted
  task automatic push(input blk_t b, input logic [1:0] ch, input logic [1:0] md);
    int t = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_block = pack(b);
    in_ch    = ch;
    mode     = md;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      #1;
      t++;
    end
    chk("push_wait", t < 50, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_block = pack(rand_blk());
    mode     = 2'($urandom);
  endtask

  task automatic drain(input blk_t b, input logic [1:0] ch, input int n, input bit stall);
    int k = 0;
    int t = 0;
    while (k < n && t < 400) begin
      @(negedge clock);
      t++;
      chk("out_valid", out_valid, 1);
      if (out_valid !== 1'b1) break;
      chk("out_idx", out_idx, k);
      chk("out_last", out_last, k == n - 1);
      chk("out_ch", out_ch, ch);
      chk_vec("out_block", out_block, exp_vec(b, n, k));
      got[k] = out_block;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) k++;
    end
    chk("drain_count", k, n);
    out_ready = 1'b1;
    @(negedge clock);
    chk("idle_after", out_valid, 0);
  endtask

  initial begin
    blk_t bA, bB;
    logic [1:0] ch;
    logic [1:0] md;

    reset_n   = 1'b0;
    mode      = 2'd0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_block  = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_ch", err_ch, 0);
    chk("rst_out_ch", out_ch, 0);
    chk_vec("rst_out_block", out_block, '0);
    @(negedge clock);
    reset_n = 1'b1;

    // 4:2:0 Cb ramp
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        bA[r][c] = DATA_W'(r * 8 + c);
    push(bA, CH_CB, MODE_420);
    drain(bA, CH_CB, 4, 1'b0);
    chk("420_i0_00", smp(got[0], 0, 0), 0);
    chk("420_i0_11", smp(got[0], 1, 1), 0);
    chk("420_i0_77", smp(got[0], 7, 7), 27);
    chk("420_i3_00", smp(got[3], 0, 0), 36);
    chk("420_i3_77", smp(got[3], 7, 7), 63);

    // 4:2:2 Cr negative ramp
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        bA[r][c] = DATA_W'(-(r * 8 + c));
    push(bA, CH_CR, MODE_422);
    drain(bA, CH_CR, 2, 1'b0);
    chk("422_i0_35", smp(got[0], 3, 5), -26);
    chk("422_i1_35", smp(got[1], 3, 5), -30);
    chk("422_i1_07", smp(got[1], 0, 7), -7);

    // Luma bypass in 4:2:0 mode
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        bA[r][c] = -9'sd256;
    push(bA, CH_Y, MODE_420);
    drain(bA, CH_Y, 1, 1'b0);
    chk("y_00", smp(got[0], 0, 0), -256);
    chk("y_77", smp(got[0], 7, 7), -256);

    // Backpressure at idx1, then zero-bubble back-to-back block
    bA = rand_blk();
    bB = rand_blk();
    push(bA, CH_CR, MODE_420);
    @(negedge clock);
    chk("bp_idx0", out_idx, 0);
    @(negedge clock);
    chk("bp_idx1", out_idx, 1);
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_hold_idx", out_idx, 1);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_last", out_last, 0);
      chk("bp_hold_in_ready", in_ready, 0);
      chk_vec("bp_hold_blk", out_block, exp_vec(bA, 4, 1));
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_idx2", out_idx, 2);
    chk_vec("bp_blk2", out_block, exp_vec(bA, 4, 2));
    @(negedge clock);
    chk("bp_idx3", out_idx, 3);
    in_valid = 1'b1;
    in_block = pack(bB);
    in_ch    = CH_CB;
    mode     = MODE_420;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_last", out_last, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_idx", out_idx, k);
      chk("b2b_ch", out_ch, CH_CB);
      chk_vec("b2b_blk", out_block, exp_vec(bB, 4, k));
    end
    @(negedge clock);
    chk("b2b_idle", out_valid, 0);

    // Illegal channel is consumed and flagged
    @(negedge clock);
    in_valid = 1'b1;
    in_ch    = 2'd3;
    mode     = MODE_420;
    #1;
    chk("ill_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("ill_err", err_ch, 1);
    chk("ill_valid", out_valid, 0);
    chk("ill_ready_after", in_ready, 1);
    @(posedge clock);
    #1;
    chk("ill_err_drop", err_ch, 0);
    chk("ill_valid2", out_valid, 0);

    // Asynchronous reset in the middle of a 4:2:0 sequence
    bA = rand_blk();
    push(bA, CH_CB, MODE_420);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("rst_mid_idx2", out_idx, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_idx", out_idx, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    bB = rand_blk();
    push(bB, CH_CR, MODE_420);
    drain(bB, CH_CR, 4, 1'b0);

    // Random blocks, channels, modes and output stalls
    for (int it = 0; it < 40; it++) begin
      bA = rand_blk();
      ch = 2'($urandom_range(0, 3));
      md = 2'($urandom_range(0, 3));
      push(bA, ch, md);
      if (ch == 2'd3) begin
        chk("rnd_ill_err", err_ch, 1);
        chk("rnd_ill_valid", out_valid, 0);
        @(posedge clock);
        #1;
        chk("rnd_ill_err_drop", err_ch, 0);
      end else begin
        drain(bA, ch, n_of(int'(md), int'(ch)), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chroma_upsample_stream.md
Name: chroma_upsample_stream

Overview:
- Streaming chroma upsampler for the decode path, placed between the IDCT/level-shift stage and colour conversion.
- Accepts one 8x8 signed block per valid/ready handshake.
- Expands chroma by nearest-neighbour replication according to the subsampling mode: 4:2:0 gives 4 blocks, 4:2:2 gives 2 blocks, 4:4:4 or luma gives 1 block.
- Emits the result as one 8x8 block per handshake, with backpressure.

Parameters:
- DATA_W, 9, signed sample width in bits.
- BLK, 8, block edge length. Must be even, at least 2.
- CH_W, 2, channel id width. Y=0, Cb=1, Cr=2; 3 is illegal.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  subsampling mode: 0=4:4:4, 1=4:2:2, 2=4:2:0, 3=reserved (treated as 4:4:4).
- in_valid  in  1  input block valid.
- in_ready  out  1  block can be accepted this cycle.
- in_ch  in  CH_W  channel id of the input block.
- in_block  in  BLK*BLK*DATA_W  signed samples, indexed [row][col].
- out_valid  out  1  out_block is valid.
- out_ready  in  1  downstream accepts out_block.
- out_block  out  BLK*BLK*DATA_W  upsampled block.
- out_ch  out  CH_W  channel id of the held block.
- out_idx  out  2  sub-block index: 0=TL, 1=TR, 2=BL, 3=BR. For 4:2:2: 0=L, 1=R.
- out_last  out  1  high on the final sub-block of the held block.
- busy  out  1  a block is held.
- err_ch  out  1  one-cycle pulse when an illegal in_ch block is dropped.

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE, in_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0, err_ch=0, out_block=0, out_ch=0.
- States:
  - IDLE: no block held.
  - EMIT: a block is held and sub-blocks are being emitted.
- Accept: accept happens when in_valid && in_ready.
  - The block is copied into the hold register.
  - in_ch and the effective count N are latched at accept.
    - N=4 if mode==2 and ch in {1,2}.
    - N=2 if mode==1 and ch in {1,2}.
    - Otherwise N=1.
  - mode changes after accept do not affect the held block.
- Latency: first out_valid appears the cycle after accept.
  - No combinational path from in_* to out_*.
  - out_block is registered.
- Replication, with qx/qy taken from the sub-block index and h=BLK/2:
  - 4:2:0: out[r][c] = hold[qy*h + r/2][qx*h + c/2]. Index k maps to qx=k[0], qy=k[1].
  - 4:2:2: out[r][c] = hold[r][k*h + c/2].
  - N=1: out = hold, unchanged.
  - No arithmetic, so sample width is preserved exactly and signed values pass bit-exact.
- EMIT:
  - out_valid=1 throughout.
  - On an out_valid && out_ready handshake: if out_idx<N-1, increment out_idx and register the next sub-block. Otherwise the block is finished.
  - Without out_ready, out_block, out_idx and out_last hold stable.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - This allows back-to-back blocks with zero bubbles.
  - On a simultaneous last-handshake and accept, go to EMIT with out_idx=0 and the new block.
  - With no new block, go to IDLE; out_valid drops the next cycle.
- Illegal channel (in_ch==3 on accept):
  - The block is consumed but not held.
  - err_ch pulses for 1 cycle; no output is produced.
  - State is unchanged: it stays IDLE, or goes to IDLE if it was finishing.
- out_last = (out_idx==N-1) while out_valid. When N=1 it is high on the single output.
- busy = (state==EMIT).
- reset_n asserted mid-EMIT: the held block is discarded immediately and no partial sequence resumes.

Decomposition:
- Shared package (upsample_pkg, or an addition to sys_defs):
  - mode enum: MODE_444, MODE_422, MODE_420.
  - channel constants: CH_Y, CH_CB, CH_CR.
  - state enum: IDLE, EMIT.
  - parametrised block typedef for the [BLK][BLK] signed DATA_W array.
- Sub-module upsample_select:
  - Purely combinational.
  - Inputs: hold block, N, index. Output: one replicated BLK x BLK block.
  - Instantiated once; its result is registered into out_block by the top module.

Test Plan:
- 4:2:0, Cb, in[r][c]=r*8+c, out_ready=1 -> 4 outputs on consecutive cycles after accept.
  - idx 0..3, out_last only on idx 3.
  - idx0 out[0][0]=out[1][1]=0, out[7][7]=27.
  - idx3 out[0][0]=36, out[7][7]=63.
- 4:2:2, Cr, in[r][c]=-(r*8+c) -> 2 outputs.
  - idx0 out[3][5]=-26.
  - idx1 out[3][5]=-30, out[0][7]=-7.
  - out_last on idx1.
- 4:2:0 with a Y block, value -256 everywhere -> single bypass output, out_last=1, all samples -256.
- Backpressure: 4:2:0 with out_ready low for 3 cycles at idx1 -> idx1 output stable for 3 cycles, in_ready=0. Then back-to-back second block accepted the same cycle as idx3 handshake -> idx0 of the new block in the next cycle, no bubble.
- in_ch=3 accepted -> err_ch pulses 1 cycle, out_valid stays 0, in_ready stays 1.
- reset_n pulled low during idx2 -> out_valid=0 and in_ready=1 immediately (asynchronous). After release, a new block starts at idx0.
